// File: rtl/alu_seq_arbiter_if.sv
// Requester-side bundle for alu_seq_arbiter: per-requester valid/ready and micro-op buses.
// Master drives requests; the arbiter uses the slave modport.
interface alu_seq_arbiter_if #(
   parameter int OP_W = 51,
   parameter int REQS = 2
);
   logic [REQS-1:0] req_valid;
   logic [REQS-1:0] req_ready;
   logic [OP_W-1:0] req_op0;
   logic [OP_W-1:0] req_op1;

   modport master (output req_valid, output req_op0, output req_op1, input req_ready);
   modport slave  (input req_valid, input req_op0, input req_op1, output req_ready);
endinterface

// File: rtl/alu_seq_arbiter.sv
// Two-requester round-robin sequencer driving a shared regfile+ALU datapath (IDLE->EXEC->WB).
// Optional macro ALU_SEQ_PERF_EN adds a 32-bit completed-op counter output op_count.
module alu_seq_arbiter #(
   parameter int OP_W = 51,
   parameter int REQS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_seq_arbiter_if.slave   req,
   input  logic               hold,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic               RegWrite,
   output logic               ALUsrc,
   output logic [2:0]         ALUctrl,
   output logic [31:0]        ImmOp,
   output logic               done,
   output logic               done_id
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [31:0]        op_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic            src_q, src_d;
   logic [2:0]      ctrl_q, ctrl_d;
   logic [31:0]     imm_q, imm_d;
   logic            regwr_q, regwr_d;
   logic            done_q, done_d;
   logic            did_q, did_d;
   logic            grant;
   logic [OP_W-1:0] op_sel;
   logic [REQS-1:0] ready_c;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      src_d   = src_q;
      ctrl_d  = ctrl_q;
      imm_d   = imm_q;
      regwr_d = regwr_q;
      done_d  = done_q;
      did_d   = did_q;
      ready_c = '0;
      // On contention the requester that did not win last time gets the slot
      grant   = (req.req_valid == 2'b11) ? ~last_q : req.req_valid[1];
      op_sel  = grant ? req.req_op1 : req.req_op0;
      case (state_q)
         IDLE: begin
            if (rst_n && !hold && (|req.req_valid)) begin
               ready_c[grant] = 1'b1;
               state_d = EXEC;
               last_d  = grant;
               did_d   = grant;
               rs1_d   = op_sel[50:46];
               rs2_d   = op_sel[45:41];
               rd_d    = op_sel[40:36];
               src_d   = op_sel[35];
               ctrl_d  = op_sel[34:32];
               imm_d   = op_sel[31:0];
            end
         end
         EXEC: begin
            if (!hold) begin
               state_d = WB;
               regwr_d = (rd_q != 5'd0);
               done_d  = 1'b1;
            end
         end
         WB: begin
            if (!hold) begin
               state_d = IDLE;
               regwr_d = 1'b0;
               done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         src_q   <= 1'b0;
         ctrl_q  <= '0;
         imm_q   <= '0;
         regwr_q <= 1'b0;
         done_q  <= 1'b0;
         did_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         src_q   <= src_d;
         ctrl_q  <= ctrl_d;
         imm_q   <= imm_d;
         regwr_q <= regwr_d;
         done_q  <= done_d;
         did_q   <= did_d;
      end
   end

`ifdef ALU_SEQ_PERF_EN
   logic [31:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (state_q == WB && !hold) op_count_d = op_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) op_count_q <= '0;
      else        op_count_q <= op_count_d;
   end

   assign op_count = op_count_q;
`endif

   assign req.req_ready = ready_c;
   assign rs1      = rs1_q;
   assign rs2      = rs2_q;
   assign rd       = rd_q;
   assign ALUsrc   = src_q;
   assign ALUctrl  = ctrl_q;
   assign ImmOp    = imm_q;
   assign RegWrite = regwr_q;
   assign done     = done_q;
   assign done_id  = did_q;

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
- Multi-cycle sequencer and round-robin arbiter that shares one register-file + ALU datapath between two requesters (e.g. main decode and a debug/init port).
- Accepts packed ALU micro-ops via valid/ready, latches fields, and drives rs1/rs2/rd/ALUsrc/ALUctrl/ImmOp/RegWrite into the datapath.
- Sequences read/execute then write-back, and returns a per-requester completion pulse.

Parameters:
- OP_W, 51, micro-op bundle width; fixed layout {rs1[50:46], rs2[45:41], rd[40:36], ALUsrc[35], ALUctrl[34:32], Imm[31:0]}
- REQS, 2, number of requesters; fixed at 2, index 0/1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester op valid
- req_ready  out  2  per-requester accept; op accepted when valid&ready
- req_op0  in  51  requester 0 micro-op bundle
- req_op1  in  51  requester 1 micro-op bundle
- hold  in  1  freeze: no new grant, FSM does not advance
- rs1  out  5  datapath read address 1
- rs2  out  5  datapath read address 2
- rd  out  5  datapath write address
- RegWrite  out  1  datapath write enable
- ALUsrc  out  1  datapath operand-2 select (1 = ImmOp)
- ALUctrl  out  3  datapath ALU operation
- ImmOp  out  32  datapath immediate
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester index of completed op; valid when done=1

Behaviour:
- Reset: rst_n=0 sampled at a clk edge gives state=IDLE; req_ready=00; rs1/rs2/rd/ALUctrl/ImmOp=0; ALUsrc=0; RegWrite=0; done=0; done_id=0; last_grant=1, so requester 0 wins first. Reset mid-op aborts the op: no RegWrite, no done.
- States: IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - req_ready is combinational. Only the granted requester's bit is 1, and only when hold=0. Grant = the single valid requester, or on contention the requester != last_grant.
  - On handshake: latch the bundle fields into the datapath output registers, set last_grant, go to EXEC.
- EXEC (one cycle): datapath outputs stable, RegWrite=0, so the register-file read and ALU settle.
- WB (one cycle): RegWrite=1 unless rd==0; with rd==0 RegWrite stays 0 (x0 protection). done=1 and done_id=granted index, both registered and coincident with WB.
- Next state after WB is IDLE.
- Latency: handshake at edge N; EXEC in cycle N+1; WB/done in cycle N+2; req_ready may reassert in cycle N+3. Throughput is one op per 3 cycles.
- hold=1 in EXEC or WB: state, outputs and RegWrite held. In WB, RegWrite and done stay asserted while held, and release after hold falls. Bench and datapath treat the write as idempotent.
- Datapath field outputs keep their last values in IDLE. They change only on a handshake.
- A requester deasserting valid without a handshake has no effect. A requester's bundle is sampled only on the handshake edge.
- Both valid every cycle gives a strict 0,1,0,1 alternation.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- Defined: adds output port op_count (32 bits). Reset 0. Increments by 1 on every cycle that leaves WB, rd==0 ops included. Wraps 0xFFFFFFFF to 0. Does not count while hold is high in WB.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then req_valid=01, op0 = rs1=1, rs2=2, rd=3, ALUsrc=0, ALUctrl=000, Imm=0 -> ready0 high in IDLE; rs1=1/rs2=2/rd=3 from N+1; RegWrite=1 and done=1, done_id=0 only in N+2; ready0 back in N+3.
- Both valid continuously, op0 rd=5, op1 rd=6 -> grants alternate 0,1,0,1; done_id sequence 0,1,0,1; first grant to requester 0.
- op1 with rd=0, ALUsrc=1, Imm=0x0000_0010 -> ALUsrc=1, ImmOp=0x10 driven; done=1 with done_id=1 in WB; RegWrite stays 0 all cycles.
- hold=1 in IDLE with req_valid=11 -> req_ready=00, no state change. hold=1 for 3 cycles in WB -> RegWrite/done held 4 cycles total, then IDLE.
- rst_n=0 during EXEC -> next cycle IDLE, RegWrite=0, done never pulses; outputs zero; next grant goes to requester 0.
- ALU_SEQ_PERF_EN: 5 completed ops (one with rd=0) -> op_count=5. Preload-forced 0xFFFFFFFF plus one op -> op_count=0.
